// File: rtl/asip_hazard_ctrl.sv
// Hazard and forwarding controller: in-flight table, load-use/branch stalls, forwarding selects.
// Forwarding is compiled in only when the macro ASIP_HAZARD_FWD_EN is defined.
module asip_hazard_ctrl #(
    parameter int STAGES     = 3,
    parameter int REG_AW     = 4,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           id_ra1,
    input  logic [REG_AW-1:0]           id_ra2,
    input  logic                        id_use1,
    input  logic                        id_use2,
    input  logic [REG_AW-1:0]           id_wa,
    input  logic                        id_reg_write,
    input  logic                        id_mem_to_reg,
    input  logic                        id_branch,
    output logic                        stall_f,
    output logic                        stall_d,
    output logic                        bubble_e,
    output logic [$clog2(STAGES+1)-1:0] fwd_a,
    output logic [$clog2(STAGES+1)-1:0] fwd_b,
    output logic [CNT_W-1:0]            lu_stall_cnt,
    output logic [CNT_W-1:0]            br_stall_cnt
);

    localparam int FW = $clog2(STAGES + 1);

`ifdef ASIP_HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [STAGES:1]   t_valid;
    logic [STAGES:1]   t_rw;
    logic [STAGES:1]   t_ld;
    logic [STAGES:1]   t_br;
    logic [REG_AW-1:0] t_wa [1:STAGES];

    logic [FW-1:0] hit_a;
    logic [FW-1:0] hit_b;
    logic          ld_a;
    logic          ld_b;
    logic          haz_a;
    logic          haz_b;
    logic          lu_stall;
    logic          br_in_table;
    logic          br_hold;

    // Scan oldest to youngest so the youngest matching writer is the one left standing.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (id_use1 && t_valid[k] && t_rw[k] && t_wa[k] == id_ra1) begin
                hit_a = FW'(k);
                ld_a  = t_ld[k];
            end
            if (id_use2 && t_valid[k] && t_rw[k] && t_wa[k] == id_ra2) begin
                hit_b = FW'(k);
                ld_b  = t_ld[k];
            end
        end
    end

    // Without forwarding, only the final stage has written the register file in time.
    always_comb begin
        haz_a = (hit_a != '0) &&
                (FWD_EN ? (ld_a && hit_a < FW'(LOAD_STAGE)) : (hit_a < FW'(STAGES)));
        haz_b = (hit_b != '0) &&
                (FWD_EN ? (ld_b && hit_b < FW'(LOAD_STAGE)) : (hit_b < FW'(STAGES)));
        lu_stall    = !rst && id_valid && (haz_a || haz_b);
        br_in_table = |(t_valid & t_br);
        br_hold     = !rst && (br_in_table || (id_valid && id_branch));
        stall_f     = lu_stall || br_hold;
        stall_d     = lu_stall;
        bubble_e    = lu_stall || (!rst && br_in_table);
        fwd_a       = (FWD_EN && !rst) ? hit_a : '0;
        fwd_b       = (FWD_EN && !rst) ? hit_b : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_valid      <= '0;
            t_rw         <= '0;
            t_ld         <= '0;
            t_br         <= '0;
            for (int k = 1; k <= STAGES; k++) t_wa[k] <= '0;
            lu_stall_cnt <= '0;
            br_stall_cnt <= '0;
        end else begin
            for (int k = 2; k <= STAGES; k++) begin
                t_valid[k] <= t_valid[k-1];
                t_rw[k]    <= t_rw[k-1];
                t_ld[k]    <= t_ld[k-1];
                t_br[k]    <= t_br[k-1];
                t_wa[k]    <= t_wa[k-1];
            end
            t_valid[1] <= id_valid && !bubble_e;
            t_rw[1]    <= id_reg_write;
            t_ld[1]    <= id_mem_to_reg;
            t_br[1]    <= id_branch;
            t_wa[1]    <= id_wa;
            if (lu_stall && lu_stall_cnt != '1)
                lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
            if (br_hold && !lu_stall && br_stall_cnt != '1)
                br_stall_cnt <= br_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_asip_hazard_ctrl.sv
// Self-checking bench for asip_hazard_ctrl: directed scenarios plus random traffic against
// an in-flight reference model; expectations follow ASIP_HAZARD_FWD_EN when it is defined.
module tb_asip_hazard_ctrl;

    localparam int ST  = 3;
    localparam int LS  = 2;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [3:0]    id_ra1;
    logic [3:0]    id_ra2;
    logic          id_use1;
    logic          id_use2;
    logic [3:0]    id_wa;
    logic          id_reg_write;
    logic          id_mem_to_reg;
    logic          id_branch;
    logic          stall_f;
    logic          stall_d;
    logic          bubble_e;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [CW-1:0] lu_stall_cnt;
    logic [CW-1:0] br_stall_cnt;

    asip_hazard_ctrl #(.STAGES(ST), .REG_AW(4), .LOAD_STAGE(LS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wa(id_wa), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .stall_f(stall_f),
        .stall_d(stall_d), .bubble_e(bubble_e), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .lu_stall_cnt(lu_stall_cnt), .br_stall_cnt(br_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: instructions that have left decode, indexed by age in cycles (1 = just issued).
    typedef struct {
        bit v;
        int wa;
        bit rw;
        bit ld;
        bit br;
    } instr_t;

    instr_t inflight [1:ST];
    int     m_lu;
    int     m_br;
    bit     cnt_known;
    int     tests;
    int     fails;
    int     sf_seen;
    int     sd_seen;
    int     bub_seen;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive decode, compare against the model, then advance both.
    task automatic applyStimulus(input bit v, input int ra1, input bit u1, input int ra2,
                                 input bit u2, input int wa, input bit rw, input bit ld,
                                 input bit br, output bit held);
        int ka, kb;
        bit la, lb, haz, lu, brt, brh, e_bub;
        int e_fa, e_fb;
        id_valid = v; id_ra1 = 4'(ra1); id_use1 = u1; id_ra2 = 4'(ra2); id_use2 = u2;
        id_wa = 4'(wa); id_reg_write = rw; id_mem_to_reg = ld; id_branch = br;
        #2;
        ka = 0; kb = 0; la = 0; lb = 0;
        for (int k = 1; k <= ST; k++) begin
            if (ka == 0 && u1 && inflight[k].v && inflight[k].rw && inflight[k].wa == ra1) begin
                ka = k; la = inflight[k].ld;
            end
            if (kb == 0 && u2 && inflight[k].v && inflight[k].rw && inflight[k].wa == ra2) begin
                kb = k; lb = inflight[k].ld;
            end
        end
`ifdef ASIP_HAZARD_FWD_EN
        haz  = (ka != 0 && la && ka < LS) || (kb != 0 && lb && kb < LS);
        e_fa = ka;
        e_fb = kb;
`else
        haz  = (ka != 0 && ka < ST) || (kb != 0 && kb < ST);
        e_fa = 0;
        e_fb = 0;
`endif
        brt = 0;
        for (int k = 1; k <= ST; k++) if (inflight[k].v && inflight[k].br) brt = 1;
        lu    = !rst && v && haz;
        brh   = !rst && (brt || (v && br));
        e_bub = lu || (!rst && brt);
        if (rst) begin e_fa = 0; e_fb = 0; end
        checkOutput("stall_f", 32'(stall_f), 32'(lu || brh));
        checkOutput("stall_d", 32'(stall_d), 32'(lu));
        checkOutput("bubble_e", 32'(bubble_e), 32'(e_bub));
        checkOutput("fwd_a", 32'(fwd_a), 32'(e_fa));
        checkOutput("fwd_b", 32'(fwd_b), 32'(e_fb));
        if (cnt_known) begin
            checkOutput("lu_cnt", 32'(lu_stall_cnt), 32'(m_lu));
            checkOutput("br_cnt", 32'(br_stall_cnt), 32'(m_br));
        end
        sf_seen  += int'(stall_f);
        sd_seen  += int'(stall_d);
        bub_seen += int'(bubble_e);
        held = lu;
        if (rst) begin
            for (int k = 1; k <= ST; k++) inflight[k] = '{0, 0, 0, 0, 0};
            m_lu = 0; m_br = 0; cnt_known = 1;
        end else begin
            for (int k = ST; k >= 2; k--) inflight[k] = inflight[k-1];
            inflight[1] = '{v && !e_bub, wa, rw, ld, br};
            if (lu && m_lu < MAX) m_lu++;
            if (brh && !lu && m_br < MAX) m_br++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        bit h;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, h);
    endtask

    // Re-presents the decode instruction until the model says it has left decode.
    task automatic issue(input int ra1, input bit u1, input int ra2, input bit u2,
                         input int wa, input bit rw, input bit ld, input bit br);
        bit h;
        int n = 0;
        do begin
            applyStimulus(1, ra1, u1, ra2, u2, wa, rw, ld, br, h);
            n++;
        end while (h && n < 16);
        checkOutput("issue_timeout", 32'(h), 32'(0));
    endtask

    initial begin
        int lu0, br0;
        bit h;
        tests = 0; fails = 0; cnt_known = 0; m_lu = 0; m_br = 0;
        sf_seen = 0; sd_seen = 0; bub_seen = 0;
        for (int k = 1; k <= ST; k++) inflight[k] = '{0, 0, 0, 0, 0};
        rst = 1'b1;
        id_valid = 0; id_ra1 = 0; id_ra2 = 0; id_use1 = 0; id_use2 = 0;
        id_wa = 0; id_reg_write = 0; id_mem_to_reg = 0; id_branch = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles while decode presents a branch.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, h);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, h);
        rst = 1'b0;
        nop(1);
        checkOutput("post_reset_lu", 32'(lu_stall_cnt), 32'(0));
        checkOutput("post_reset_br", 32'(br_stall_cnt), 32'(0));

        // ALU chain: ADD r3, SUB r3, then a second reader of r3.
        sf_seen = 0;
        issue(0, 0, 0, 0, 3, 1, 0, 0);
        issue(3, 1, 1, 1, 4, 1, 0, 0);
        issue(3, 1, 0, 0, 6, 1, 0, 0);
`ifdef ASIP_HAZARD_FWD_EN
        checkOutput("alu_chain_stalls", 32'(sf_seen), 32'(0));
`else
        checkOutput("alu_chain_stalls", 32'(sf_seen), 32'(2));
`endif
        nop(4);

        // Load-use on source 2.
        sd_seen = 0;
        lu0 = int'(lu_stall_cnt);
        issue(0, 0, 0, 0, 5, 1, 1, 0);
        issue(7, 1, 5, 1, 8, 1, 0, 0);
        nop(4);
`ifdef ASIP_HAZARD_FWD_EN
        checkOutput("load_use_stalls", 32'(sd_seen), 32'(1));
        checkOutput("load_use_cnt", 32'(int'(lu_stall_cnt) - lu0), 32'(1));
`else
        checkOutput("load_use_stalls", 32'(sd_seen), 32'(2));
        checkOutput("load_use_cnt", 32'(int'(lu_stall_cnt) - lu0), 32'(2));
`endif

        // Branch latency: stall_f for STAGES+1 cycles, bubbles for STAGES.
        sf_seen = 0; bub_seen = 0;
        br0 = int'(br_stall_cnt);
        issue(0, 0, 0, 0, 0, 0, 0, 1);
        nop(5);
        checkOutput("branch_stall_f", 32'(sf_seen), 32'(ST + 1));
        checkOutput("branch_bubble", 32'(bub_seen), 32'(ST));
        checkOutput("branch_cnt", 32'(int'(br_stall_cnt) - br0), 32'(ST + 1));

        // Load followed by a dependent branch: load-use first, then the branch hold.
        lu0 = int'(lu_stall_cnt);
        br0 = int'(br_stall_cnt);
        issue(0, 0, 0, 0, 2, 1, 1, 0);
        issue(2, 1, 0, 0, 0, 0, 0, 1);
        nop(5);
`ifdef ASIP_HAZARD_FWD_EN
        checkOutput("prio_lu_cnt", 32'(int'(lu_stall_cnt) - lu0), 32'(1));
`else
        checkOutput("prio_lu_cnt", 32'(int'(lu_stall_cnt) - lu0), 32'(2));
`endif
        checkOutput("prio_br_cnt", 32'(int'(br_stall_cnt) - br0), 32'(ST + 1));

        // Reset in the middle of a branch hold.
        issue(0, 0, 0, 0, 0, 0, 0, 1);
        nop(1);
        rst = 1'b1;
        nop(1);
        rst = 1'b0;
        nop(1);
        checkOutput("reset_mid_stall_f", 32'(stall_f), 32'(0));
        nop(1);

        // Random traffic over a small register window to provoke dependences.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 9) == 0, h);
        end
        rst = 1'b0;

        // Saturation: continuous branches, then self-dependent loads.
        for (int i = 0; i < MAX + 40; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, h);
        nop(4);
        for (int i = 0; i < 3 * MAX + 60; i++) applyStimulus(1, 1, 1, 0, 0, 1, 1, 1, 0, h);
        nop(4);
        checkOutput("br_saturated", 32'(br_stall_cnt), 32'(MAX));
        checkOutput("lu_saturated", 32'(lu_stall_cnt), 32'(MAX));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/asip_hazard_ctrl.md
# asip_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined vector ASIP. It tracks every instruction issued from decode through a configurable number of post-decode stages (default E, M, W) in an internal in-flight table. From that table it produces fetch/decode stalls, decode bubbles and per-operand forwarding selects, plus saturating stall counters for performance analysis. It replaces the branch-only fetch stall of the current core with load-use detection, forwarding and a depth-generic branch hold.

## Interface
- `STAGES`, 3: post-decode stages tracked; stage 1 = E, stage `STAGES` = W; legal range 2..8.
- `REG_AW`, 4: register address width (16 architectural registers).
- `LOAD_STAGE`, 2: first stage whose result bus carries load data; must satisfy 1 < `LOAD_STAGE` <= `STAGES`.
- `CNT_W`, 16: width of each stall counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: decode holds a real instruction.
- `id_ra1`, `id_ra2` input `REG_AW`: source register addresses in decode.
- `id_use1`, `id_use2` input 1: the matching source is actually read.
- `id_wa` input `REG_AW`: destination register.
- `id_reg_write` input 1: instruction writes the register file.
- `id_mem_to_reg` input 1: instruction is a load.
- `id_branch` input 1: instruction writes the PC.
- `stall_f` output 1: hold PC and the fetch/decode register.
- `stall_d` output 1: hold the decode instruction. Load-use stalls only.
- `bubble_e` output 1: load an invalid entry into the D/E register this cycle.
- `fwd_a`, `fwd_b` output `$clog2(STAGES+1)`: 0 = register file, k = result bus of stage k.
- `lu_stall_cnt`, `br_stall_cnt` output `CNT_W`: saturating counts of load-use and branch stall cycles.

## Operation
- **In-flight table.** `STAGES` entries of {valid, wa, reg_write, load, branch}. Each cycle entries shift k→k+1, and entry `STAGES` retires.
- **Stage 1 load.**
  - Stage 1 takes the decode instruction when `id_valid` is high and `bubble_e` is low.
  - Otherwise stage 1 takes an invalid entry.
- **Operand match.** Source n matches stage k when `id_usen`, entry k valid, entry k reg_write, and wa == `id_ran`.
  - The youngest match (smallest k) wins.
  - `fwd_n` = k, or 0 when there is no match.
  - Matches are recomputed every cycle.
- **Load-use.** If the winning match for either source is a load with k < `LOAD_STAGE`:
  - `stall_f` = `stall_d` = `bubble_e` = 1 that cycle.
  - `lu_stall_cnt` increments.
- **Branch hold.** If `id_branch` (valid) is in decode, or any valid entry has branch = 1:
  - `stall_f` = 1.
  - Once the branch itself has left decode, `bubble_e` = 1.
  - `br_stall_cnt` increments on every cycle that is not already counted as load-use.
- **Priority.** Load-use stall takes precedence over branch hold.
  - A branch in decode with a load-use hazard waits in decode.
  - It enters stage 1 only after the hazard clears.
- **Counters.** Saturate at all-ones and do not wrap.
- **Encoding.** No register is hard-wired to zero; register 0 forwards like any other.

## Timing
- **Reset values.**
  - All entries invalid.
  - `stall_f` = `stall_d` = `bubble_e` = 0.
  - `fwd_a` = `fwd_b` = 0.
  - Counters 0.
- **Reset mid-operation.** Clears the table in the same edge. The cycle after `rst` falls shows no stall unless decode inputs demand one.
- **Output timing.** All control outputs are combinational from the table and decode inputs, valid in the same cycle. The table and counters are registered.
- **Load-use latency.** With `LOAD_STAGE` = 2, a dependent instruction immediately behind a load stalls exactly 1 cycle. It then issues with `fwd` = 2.
- **Branch latency.** A branch in decode at cycle t gives `stall_f` high for cycles t..t+`STAGES`, and fetch resumes at t+`STAGES`+1. With `STAGES` = 3 that is 4 stall cycles, matching the existing core.
- **Back-to-back.** Back-to-back independent instructions issue one per cycle with no stall.

## Configuration
- **`ASIP_HAZARD_FWD_EN` defined.** Forwarding as above.
- **`ASIP_HAZARD_FWD_EN` undefined.**
  - `fwd_a` = `fwd_b` = 0 permanently.
  - Any match in stages 1..`STAGES`-1 is treated as a load-use hazard: stall, bubble, `lu_stall_cnt`++.
  - A writer at stage `STAGES` is assumed to write the register file before it is read, so it raises no stall.

## Test plan
- **Reset.** Assert `rst` 2 cycles with decode driving a branch → all outputs 0 and counters 0 during and after reset.
- **ALU chain (forwarding on).** ADD r3 then SUB reading r3 next cycle → `fwd_a` = 1, no stall. A second reader one cycle later → `fwd_a` = 2.
- **Load-use.** LOAD r5, then ADD reading r5 as src2 → 1 cycle of `stall_f` = `stall_d` = `bubble_e` = 1, then `fwd_b` = 2; `lu_stall_cnt` = 1.
- **Branch with `STAGES` = 3.** Branch at cycle 10 → `stall_f` high cycles 10–13, `bubble_e` high 11–13, `br_stall_cnt` = 4. With `STAGES` = 5 → `stall_f` high 10–15.
- **Priority and reset mid-operation.** LOAD r2 then branch reading r2 → 1 load-use cycle, then 4 branch cycles; counters 1/4. Assert `rst` during the branch hold → next cycle `stall_f` = 0.
- **Forwarding compiled out.** Without `ASIP_HAZARD_FWD_EN`, ADD r3 then dependent SUB → 2 stall cycles, `fwd_a` stays 0; `lu_stall_cnt` = 2.
- **Counter saturation.** Preload the counters to 0xFFFF via a long branch loop → they hold at 0xFFFF.
